// File: rtl/rf_pkg.sv
// Shared constants and helpers for the reg_file block (reserved addresses, reset values, parity).
// Parity storage in reg_file is enabled by defining RF_PARITY_EN.
package rf_pkg;

  localparam int DATA_W = 8;

  localparam int ALU_OPA_ADDR   = 0;
  localparam int ALU_OPB_ADDR   = 1;
  localparam int UART_CFG_ADDR  = 2;
  localparam int DIV_RATIO_ADDR = 3;

  // UART: prescale 32, parity enabled, even parity
  localparam logic [DATA_W-1:0] UART_CFG_RST  = 8'h81;
  localparam logic [DATA_W-1:0] DIV_RATIO_RST = 8'd32;

  // Even-parity bit: makes the total number of ones in {word, bit} even
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/rf_parity.sv
// Combinational even-parity generator over WIDTH bits.
// Instantiated by reg_file only when RF_PARITY_EN is defined.
module rf_parity #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_o
);

  assign parity_o = ^data_i;

endmodule

// File: rtl/reg_file.sv
// Flop-based register file with registered read data and one-cycle valid; entries 0..3 drive REG0..REG3.
// Define RF_PARITY_EN to add per-entry even parity and the RdData_ERR output.
module reg_file
  import rf_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ADDR  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WrEn,
  input  logic             RdEn,
  input  logic [ADDR-1:0]  Address,
  input  logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] RdData,
  output logic             RdData_VLD,
`ifdef RF_PARITY_EN
  output logic             RdData_ERR,
`endif
  output logic [WIDTH-1:0] REG0,
  output logic [WIDTH-1:0] REG1,
  output logic [WIDTH-1:0] REG2,
  output logic [WIDTH-1:0] REG3
);

  localparam int DEPTH = 1 << ADDR;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_vld_q, rd_vld_d;
  logic             rd_sel;

  // A simultaneous write wins; the read is dropped
  assign rd_sel = RdEn && !WrEn;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == UART_CFG_ADDR)       mem_q[i] <= WIDTH'(UART_CFG_RST);
        else if (i == DIV_RATIO_ADDR) mem_q[i] <= WIDTH'(DIV_RATIO_RST);
        else                          mem_q[i] <= '0;
      end
    end else if (WrEn) begin
      mem_q[Address] <= WrData;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    rd_vld_d  = 1'b0;
    if (rd_sel) begin
      rd_data_d = mem_q[Address];
      rd_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

`ifdef RF_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic             wr_par, rd_par;
  logic             rd_err_q, rd_err_d;

  rf_parity #(.WIDTH(WIDTH)) u_wr_par (.data_i(WrData),         .parity_o(wr_par));
  rf_parity #(.WIDTH(WIDTH)) u_rd_par (.data_i(mem_q[Address]), .parity_o(rd_par));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == UART_CFG_ADDR)       par_q[i] <= even_parity(UART_CFG_RST);
        else if (i == DIV_RATIO_ADDR) par_q[i] <= even_parity(DIV_RATIO_RST);
        else                          par_q[i] <= 1'b0;
      end
    end else if (WrEn) begin
      par_q[Address] <= wr_par;
    end
  end

  always_comb begin
    rd_err_d = 1'b0;
    if (rd_sel) rd_err_d = rd_par ^ par_q[Address];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rd_err_q <= 1'b0;
    else     rd_err_q <= rd_err_d;
  end

  assign RdData_ERR = rd_err_q;
`endif

  assign RdData     = rd_data_q;
  assign RdData_VLD = rd_vld_q;
  assign REG0       = mem_q[ALU_OPA_ADDR];
  assign REG1       = mem_q[ALU_OPB_ADDR];
  assign REG2       = mem_q[UART_CFG_ADDR];
  assign REG3       = mem_q[DIV_RATIO_ADDR];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus random traffic against an array model.
// Parity scenarios compile only when RF_PARITY_EN is defined.
module tb_reg_file;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       WrEn = 1'b0;
  logic       RdEn = 1'b0;
  logic [3:0] Address = '0;
  logic [7:0] WrData = '0;
  logic [7:0] RdData, REG0, REG1, REG2, REG3;
  logic       RdData_VLD;
`ifdef RF_PARITY_EN
  logic       RdData_ERR;
`endif

  int tests  = 0;
  int errors = 0;

  reg_file #(.WIDTH(8), .ADDR(4)) dut (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .RdData(RdData), .RdData_VLD(RdData_VLD),
`ifdef RF_PARITY_EN
    .RdData_ERR(RdData_ERR),
`endif
    .REG0(REG0), .REG1(REG1), .REG2(REG2), .REG3(REG3)
  );

  always #5 CLK = ~CLK;

  // Reference model: plain array plus last-read registers
  logic [7:0] m_mem [16];
  logic       m_bad [16];
  logic [7:0] m_rd;
  logic       m_vld;
  logic       m_err;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) begin m_mem[i] = 8'h00; m_bad[i] = 1'b0; end
      m_mem[2] = 8'h81;
      m_mem[3] = 8'h20;
      m_rd = 8'h00; m_vld = 1'b0; m_err = 1'b0;
    end else begin
      m_vld = 1'b0;
      m_err = 1'b0;
      if (WrEn) begin
        m_mem[Address] = WrData;
        m_bad[Address] = 1'b0;
      end else if (RdEn) begin
        m_rd  = m_mem[Address];
        m_vld = 1'b1;
        m_err = m_bad[Address];
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  logic model_on = 1'b0;
  always @(negedge CLK) begin
    if (model_on) begin
      chk("m_REG0", REG0, m_mem[0]);
      chk("m_REG1", REG1, m_mem[1]);
      chk("m_REG2", REG2, m_mem[2]);
      chk("m_REG3", REG3, m_mem[3]);
      chk("m_VLD", {7'b0, RdData_VLD}, {7'b0, m_vld});
      chk("m_RdData", RdData, m_rd);
`ifdef RF_PARITY_EN
      chk("m_ERR", {7'b0, RdData_ERR}, {7'b0, m_err});
`endif
    end
  end

  task automatic drive(input logic we, input logic re, input logic [3:0] a, input logic [7:0] d);
    @(negedge CLK);
    WrEn = we; RdEn = re; Address = a; WrData = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 8'h00);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    model_on = 1'b1;
    idle();
    chk("rst_REG0", REG0, 8'h00);
    chk("rst_REG1", REG1, 8'h00);
    chk("rst_REG2", REG2, 8'h81);
    chk("rst_REG3", REG3, 8'h20);
    chk("rst_RdData", RdData, 8'h00);
    chk("rst_VLD", {7'b0, RdData_VLD}, 8'h00);

    drive(1'b1, 1'b0, 4'd0,  8'hA5);
    drive(1'b1, 1'b0, 4'd15, 8'h3C);
    chk("wr_REG0", REG0, 8'hA5);
    drive(1'b0, 1'b1, 4'd0,  8'h00);
    drive(1'b0, 1'b1, 4'd15, 8'h00);
    chk("rd0_data", RdData, 8'hA5);
    chk("rd0_vld", {7'b0, RdData_VLD}, 8'h01);
    idle();
    chk("rd15_data", RdData, 8'h3C);
    chk("rd15_vld", {7'b0, RdData_VLD}, 8'h01);
    idle();
    chk("hold_vld", {7'b0, RdData_VLD}, 8'h00);
    chk("hold_data", RdData, 8'h3C);

    drive(1'b1, 1'b0, 4'd9, 8'h55);
    drive(1'b0, 1'b1, 4'd9, 8'h00);
    idle();
    chk("wr_rd9", RdData, 8'h55);

    drive(1'b1, 1'b1, 4'd3, 8'h08);
    idle();
    chk("both_REG3", REG3, 8'h08);
    chk("both_vld", {7'b0, RdData_VLD}, 8'h00);
    chk("both_data", RdData, 8'h55);

    drive(1'b0, 1'b1, 4'd0, 8'h00);
    drive(1'b0, 1'b1, 4'd1, 8'h00);
    chk("b2b0", RdData, 8'hA5);
    drive(1'b0, 1'b1, 4'd2, 8'h00);
    chk("b2b1", RdData, 8'h00);
    chk("b2b1_vld", {7'b0, RdData_VLD}, 8'h01);
    drive(1'b0, 1'b1, 4'd3, 8'h00);
    chk("b2b2", RdData, 8'h81);
    idle();
    chk("b2b3", RdData, 8'h08);
    chk("b2b3_vld", {7'b0, RdData_VLD}, 8'h01);

    // Asynchronous reset while a valid pulse is showing
    drive(1'b0, 1'b1, 4'd15, 8'h00);
    idle();
    chk("pre_rst_vld", {7'b0, RdData_VLD}, 8'h01);
    #1 RST = 1'b1;
    #1;
    chk("async_vld", {7'b0, RdData_VLD}, 8'h00);
    chk("async_data", RdData, 8'h00);
    chk("async_REG0", REG0, 8'h00);
    chk("async_REG3", REG3, 8'h20);
    @(negedge CLK);
    RST = 1'b0;
    idle();
    chk("post_rst_vld", {7'b0, RdData_VLD}, 8'h00);
    drive(1'b0, 1'b1, 4'd7, 8'h00);
    idle();
    chk("rst_rd7", RdData, 8'h00);
    chk("rst_rd7_vld", {7'b0, RdData_VLD}, 8'h01);
    idle();
    chk("rst_rd7_pulse", {7'b0, RdData_VLD}, 8'h00);

`ifdef RF_PARITY_EN
    drive(1'b1, 1'b0, 4'd5, 8'h01);
    idle();
    force dut.par_q[5] = 1'b0;
    m_bad[5] = 1'b1;
    drive(1'b0, 1'b1, 4'd5, 8'h00);
    idle();
    chk("par_data", RdData, 8'h01);
    chk("par_err", {7'b0, RdData_ERR}, 8'h01);
    drive(1'b0, 1'b1, 4'd2, 8'h00);
    idle();
    chk("par_ok2", {7'b0, RdData_ERR}, 8'h00);
    release dut.par_q[5];
    drive(1'b1, 1'b0, 4'd5, 8'h01);
    idle();
`endif

    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = int'($urandom_range(0, 99));
      drive(sel < 35, (sel >= 30) && (sel < 80), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end
    idle();
    idle();
    model_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
